// File: rtl/clk_div_mon_pkg.sv
// rtl/clk_div_mon_pkg.sv - shared state encoding, fault codes and counter width helper
package clk_div_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_LOW   = 2'd1;
  localparam logic [1:0] FC_HIGH  = 2'd2;
  localparam logic [1:0] FC_STUCK = 2'd3;

  // Bits needed to hold values 0..n for a power-of-2 n (and enough for any n >= 1).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/clk_div_mon_edge_sync.sv
// rtl/clk_div_mon_edge_sync.sv - multi-flop synchronizer plus rising-edge detector
module clk_div_mon_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - divide-by-2 clock health monitor (window edge count, lock, sticky fault)
// Optional stuck-clock detector enabled by defining CLK_DIV_MON_STUCK_DET_EN.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int WINDOW       = 1024,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4,
  parameter int STUCK_CYC    = 8
) (
  input  logic                        CLK_IN,
  input  logic                        RESET_N,
  input  logic                        DIV_CLK,
  input  logic                        EN,
  input  logic                        CLR_FAULT,
  output logic                        LOCKED,
  output logic                        FAULT,
  output logic [1:0]                  FAULT_CODE,
  output logic [$clog2(WINDOW):0]     EDGE_COUNT,
  output logic                        MEAS_VALID
);

  localparam int CW = cnt_w(WINDOW);
  localparam int WW = $clog2(WINDOW);
  localparam logic [CW-1:0] LO_LIM = CW'(WINDOW / 2 - TOL);
  localparam logic [CW-1:0] HI_LIM = CW'(WINDOW / 2 + TOL);

  state_t          state;
  logic [WW-1:0]   win_cnt;
  logic [CW-1:0]   edge_cnt;
  logic [CW-1:0]   edge_sum;
  logic [3:0]      good_cnt;
  logic            edge_pulse;
  logic            win_last;
  logic            count_low;
  logic            count_high;
  logic            stuck_hit;
  logic            running;

  clk_div_mon_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk       (CLK_IN),
    .reset_n   (RESET_N),
    .din       (DIV_CLK),
    .edge_pulse(edge_pulse)
  );

  // Count including this cycle's edge, so the final window cycle is never lost.
  assign edge_sum   = (edge_pulse && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
  assign win_last   = (win_cnt == WW'(WINDOW - 1));
  assign count_low  = (edge_sum < LO_LIM);
  assign count_high = (edge_sum > HI_LIM);
  assign running    = EN && ((state == ST_ACQUIRE) || (state == ST_LOCKED));

`ifdef CLK_DIV_MON_STUCK_DET_EN
  localparam int SW = cnt_w(STUCK_CYC);
  logic [SW-1:0] stuck_cnt;

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N || !running) begin
      stuck_cnt <= '0;
    end else begin
      stuck_cnt <= edge_pulse ? SW'(1) : stuck_cnt + 1'b1;
    end
  end

  assign stuck_hit = running && !edge_pulse && (stuck_cnt == SW'(STUCK_CYC - 1));
`else
  // Without the detector a dead clock simply shows up as a low count at window end.
  assign stuck_hit = (STUCK_CYC < 0);
`endif

  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      good_cnt   <= '0;
      LOCKED     <= 1'b0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
      EDGE_COUNT <= '0;
      MEAS_VALID <= 1'b0;
    end else begin
      MEAS_VALID <= 1'b0;
      if (!EN) begin
        state    <= ST_IDLE;
        LOCKED   <= 1'b0;
        win_cnt  <= '0;
        edge_cnt <= '0;
        good_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ACQUIRE;
          end
          ST_ACQUIRE, ST_LOCKED: begin
            win_cnt  <= win_cnt + 1'b1;
            edge_cnt <= win_last ? '0 : edge_sum;
            if (win_last) begin
              EDGE_COUNT <= edge_sum;
              MEAS_VALID <= 1'b1;
            end
            if (stuck_hit) begin
              state      <= ST_FAULT;
              LOCKED     <= 1'b0;
              FAULT      <= 1'b1;
              FAULT_CODE <= FC_STUCK;
              good_cnt   <= '0;
            end else if (win_last) begin
              if (count_low || count_high) begin
                state      <= ST_FAULT;
                LOCKED     <= 1'b0;
                FAULT      <= 1'b1;
                FAULT_CODE <= count_low ? FC_LOW : FC_HIGH;
                good_cnt   <= '0;
              end else if (state == ST_ACQUIRE) begin
                good_cnt <= good_cnt + 4'd1;
                if (good_cnt + 4'd1 == 4'(LOCK_WINDOWS)) begin
                  state  <= ST_LOCKED;
                  LOCKED <= 1'b1;
                end
              end
            end
          end
          ST_FAULT: begin
            // Leaving a fault starts a fresh, aligned window.
            if (CLR_FAULT) begin
              state      <= ST_ACQUIRE;
              FAULT      <= 1'b0;
              FAULT_CODE <= FC_NONE;
              good_cnt   <= '0;
              win_cnt    <= '0;
              edge_cnt   <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - directed self-checking bench for clk_div_monitor
module tb_clk_div_monitor;
  import clk_div_mon_pkg::*;

  logic       CLK_IN;
  logic       RESET_N;
  logic       DIV_CLK;
  logic       EN;
  logic       CLR_FAULT;
  logic       LOCKED;
  logic       FAULT;
  logic [1:0] FAULT_CODE;
  logic [6:0] EDGE_COUNT;
  logic       MEAS_VALID;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  clk_div_monitor #(
    .SYNC_STAGES (2),
    .WINDOW      (64),
    .TOL         (2),
    .LOCK_WINDOWS(4),
    .STUCK_CYC   (8)
  ) dut (
    .CLK_IN    (CLK_IN),
    .RESET_N   (RESET_N),
    .DIV_CLK   (DIV_CLK),
    .EN        (EN),
    .CLR_FAULT (CLR_FAULT),
    .LOCKED    (LOCKED),
    .FAULT     (FAULT),
    .FAULT_CODE(FAULT_CODE),
    .EDGE_COUNT(EDGE_COUNT),
    .MEAS_VALID(MEAS_VALID)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  // Divided-clock generator: 0 hold low, 1 div-by-2, 2 div-by-4, 3 hold high.
  initial begin
    int ph;
    ph = 0;
    DIV_CLK = 1'b0;
    forever begin
      @(negedge CLK_IN);
      ph++;
      case (mode)
        1: DIV_CLK = ~DIV_CLK;
        2: if (ph[0]) DIV_CLK = ~DIV_CLK;
        3: DIV_CLK = 1'b1;
        default: DIV_CLK = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_meas(input string tag);
    int i;
    i = 0;
    do begin
      @(negedge CLK_IN);
      i++;
    end while (MEAS_VALID !== 1'b1 && i < 200);
    check({tag, "_meas"}, MEAS_VALID, 1);
  endtask

  task automatic pulse_clr();
    CLR_FAULT = 1'b1;
    @(negedge CLK_IN);
    CLR_FAULT = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, LOCKED, 0);
    check({tag, "_fault"}, FAULT, 0);
    check({tag, "_code"}, FAULT_CODE, 0);
    check({tag, "_count"}, EDGE_COUNT, 0);
    check({tag, "_valid"}, MEAS_VALID, 0);
  endtask

  initial begin
    int cyc;
    int last_e;
    RESET_N   = 1'b0;
    EN        = 1'b0;
    CLR_FAULT = 1'b0;
    mode      = 1;
    repeat (4) @(negedge CLK_IN);
    check_all_zero("reset");
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_IN);

    // Ideal div-by-2: 32 edges per 64-cycle window, lock on the 4th window.
    EN = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_meas($sformatf("lock%0d", k));
      check($sformatf("lock%0d_count", k), EDGE_COUNT, 32);
      check($sformatf("lock%0d_locked", k), LOCKED, (k == 4) ? 1 : 0);
    end

    // Div-by-4 after lock: about 16 edges, count-low fault.
    mode = 2;
    wait_meas("div4");
    check("div4_count_range", (EDGE_COUNT >= 14 && EDGE_COUNT <= 19) ? 1 : 0, 1);
    check("div4_fault", FAULT, 1);
    check("div4_code", FAULT_CODE, FC_LOW);
    check("div4_locked", LOCKED, 0);

    // Glitching clock: edges seen every cycle for 40 cycles, then 12 real edges.
    mode = 1;
    repeat (10) @(negedge CLK_IN);
    check("fault_held", FAULT, 1);
    pulse_clr();
    check("clr_fault", FAULT, 0);
    check("clr_code", FAULT_CODE, FC_NONE);
    check("clr_state", dut.state, ST_ACQUIRE);
    force dut.edge_pulse = 1'b1;
    repeat (40) @(negedge CLK_IN);
    release dut.edge_pulse;
    wait_meas("glitch");
    check("glitch_count", EDGE_COUNT, 52);
    check("glitch_fault", FAULT, 1);
    check("glitch_code", FAULT_CODE, FC_HIGH);

    // Stuck-high clock mid-window.
    pulse_clr();
    repeat (20) @(negedge CLK_IN);
    check("pre_stuck_fault", FAULT, 0);
    mode = 3;
`ifdef CLK_DIV_MON_STUCK_DET_EN
    cyc = 0;
    last_e = -100;
    while (FAULT !== 1'b1 && cyc < 100) begin
      @(negedge CLK_IN);
      cyc++;
      if (dut.edge_pulse === 1'b1) last_e = cyc;
    end
    check("stuck_fault", FAULT, 1);
    check("stuck_code", FAULT_CODE, FC_STUCK);
    check("stuck_latency", cyc - last_e, 8);
`else
    cyc = 0;
    last_e = 0;
    wait_meas("stuck");
    check("stuck_fault", FAULT, 1);
    check("stuck_code", FAULT_CODE, FC_LOW);
    check("stuck_locked", LOCKED, 0);
`endif

    // Relock, then a one-cycle reset mid-window.
    mode = 1;
    repeat (10) @(negedge CLK_IN);
    pulse_clr();
    for (int k = 1; k <= 4; k++) wait_meas($sformatf("relock%0d", k));
    check("relock_locked", LOCKED, 1);
    repeat (20) @(negedge CLK_IN);
    RESET_N = 1'b0;
    @(negedge CLK_IN);
    check_all_zero("midreset");
    RESET_N = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_meas($sformatf("postrst%0d", k));
      check($sformatf("postrst%0d_count", k), EDGE_COUNT, 32);
      check($sformatf("postrst%0d_locked", k), LOCKED, (k == 4) ? 1 : 0);
    end

    // Enable drop while locked: lock drops, count holds, window restarts from 0.
    repeat (10) @(negedge CLK_IN);
    EN = 1'b0;
    @(negedge CLK_IN);
    check("en_off_locked", LOCKED, 0);
    check("en_off_count", EDGE_COUNT, 32);
    check("en_off_state", dut.state, ST_IDLE);
    repeat (10) @(negedge CLK_IN);
    check("en_off_fault", FAULT, 0);
    EN = 1'b1;
    cyc = 0;
    do begin
      @(negedge CLK_IN);
      cyc++;
    end while (MEAS_VALID !== 1'b1 && cyc < 200);
    check("en_on_latency", cyc, 65);
    check("en_on_count", EDGE_COUNT, 32);
    check("en_on_locked", LOCKED, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
